// File: rtl/hmlf6_state_update.sv
// -----------------------------------------------------------------------------
// hmlf6_state_update
//
// State update for a six-element unit-element shaper. Each accepted selection
// vector advances six candidate states. An external six-input min stage
// returns their minimum combinationally, and the block subtracts it so that
// the stored shaping states stay normalized (the smallest state is zero).
//
// Configuration macro: HMLF6_SAT_EN
//   defined   : candidate and normalized results are clamped to -32..31, and
//               sat_flag records any clamp (sticky; sat_clr wins on a tie).
//   undefined : results wrap to 6-bit two's complement, and sat_flag is 0.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   a selection vector is present on sel
//   in_ready       out  block accepts a vector this cycle (state ACC)
//   sel[5:0]       in   unit-element usage vector, bit i = element i on
//   cand5..cand0   out  registered candidate states, to min stage a5..a0
//   min_in         in   min(cand5..cand0) from the min stage
//   st5..st0       out  normalized shaping states
//   out_valid      out  one-cycle pulse after st5..st0 were updated
//   sat_flag       out  sticky saturation indicator
//   sat_clr        in   synchronous clear of sat_flag
//   state_dbg_o    out  FSM state (0 = ACC, 1 = NORM)
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. Vectors that are
// offered while in_ready is low are ignored, not queued, and sel is don't-care
// unless in_valid is high.
// -----------------------------------------------------------------------------
module hmlf6_state_update (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        sel,
  output logic signed [5:0] cand5,
  output logic signed [5:0] cand4,
  output logic signed [5:0] cand3,
  output logic signed [5:0] cand2,
  output logic signed [5:0] cand1,
  output logic signed [5:0] cand0,
  input  logic signed [5:0] min_in,
  output logic signed [5:0] st5,
  output logic signed [5:0] st4,
  output logic signed [5:0] st3,
  output logic signed [5:0] st2,
  output logic signed [5:0] st1,
  output logic signed [5:0] st0,
  output logic              out_valid,
  output logic              sat_flag,
  input  logic              sat_clr,
  output logic              state_dbg_o
);

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_NORM = 1'b1;

  logic              state_q, state_d;
  logic signed [5:0] cand_q [6];
  logic signed [5:0] cand_d [6];
  logic signed [5:0] st_q   [6];
  logic signed [5:0] st_d   [6];
  logic              out_valid_q, out_valid_d;

  // 8-bit intermediates: st + popcount - 6 spans -38..37, and
  // cand - min spans -63..63, so neither can overflow before fitting.
  logic [3:0]        pop;
  logic signed [7:0] cand_sum [6];
  logic signed [7:0] st_diff  [6];
  logic signed [5:0] cand_fit [6];
  logic signed [5:0] st_fit   [6];
  logic [5:0]        cand_clip;
  logic [5:0]        st_clip;
  logic              sat_set;

`ifdef HMLF6_SAT_EN
  function automatic logic [5:0] clamp6(input logic signed [7:0] v);
    if (v > 8'sd31)
      return 6'b011111;
    else if (v < -8'sd32)
      return 6'b100000;
    else
      return v[5:0];
  endfunction

  function automatic logic out_of_range(input logic signed [7:0] v);
    return (v > 8'sd31) || (v < -8'sd32);
  endfunction
`endif

  // Raw arithmetic for both update steps.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 6; i++) begin
      pop = pop + {3'b000, sel[i]};
    end
    for (int i = 0; i < 6; i++) begin
      cand_sum[i] = {{2{st_q[i][5]}}, st_q[i]} + {4'b0000, pop}
                    - (sel[i] ? 8'd6 : 8'd0);
      st_diff[i]  = {{2{cand_q[i][5]}}, cand_q[i]}
                    - {{2{min_in[5]}}, min_in};
    end
  end

  // Fit the 8-bit results back into 6 bits: clamp or wrap.
  always_comb begin
    cand_clip = '0;
    st_clip   = '0;
    for (int i = 0; i < 6; i++) begin
`ifdef HMLF6_SAT_EN
      cand_fit[i]  = clamp6(cand_sum[i]);
      st_fit[i]    = clamp6(st_diff[i]);
      cand_clip[i] = out_of_range(cand_sum[i]);
      st_clip[i]   = out_of_range(st_diff[i]);
`else
      cand_fit[i]  = cand_sum[i][5:0];
      st_fit[i]    = st_diff[i][5:0];
`endif
    end
  end

  // Two-state FSM: ACC takes a vector and builds candidates, NORM
  // subtracts the returned minimum. min_in is consumed only in NORM,
  // when it reflects the candidates registered on the previous edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    sat_set     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cand_d[i] = cand_q[i];
      st_d[i]   = st_q[i];
    end
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          for (int i = 0; i < 6; i++) begin
            cand_d[i] = cand_fit[i];
          end
          sat_set = |cand_clip;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        for (int i = 0; i < 6; i++) begin
          st_d[i] = st_fit[i];
        end
        sat_set     = |st_clip;
        out_valid_d = 1'b1;
        state_d     = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        cand_q[i] <= '0;
        st_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 6; i++) begin
        cand_q[i] <= cand_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

`ifdef HMLF6_SAT_EN
  logic sat_q, sat_d;

  // Clear beats set: a clamp coinciding with sat_clr is deliberately lost.
  always_comb begin
    sat_d = sat_q | sat_set;
    if (sat_clr) sat_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  // Wrapping build: the upper intermediate bits and the clear input have
  // no consumer, so they are gathered here on purpose.
  logic unused_wrap;

  always_comb begin
    unused_wrap = sat_clr ^ sat_set ^ (|cand_clip) ^ (|st_clip);
    for (int i = 0; i < 6; i++) begin
      unused_wrap = unused_wrap ^ (^cand_sum[i][7:6]) ^ (^st_diff[i][7:6]);
    end
  end

  assign sat_flag = 1'b0;
`endif

  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = out_valid_q;
  assign state_dbg_o = state_q;

  assign cand0 = cand_q[0];
  assign cand1 = cand_q[1];
  assign cand2 = cand_q[2];
  assign cand3 = cand_q[3];
  assign cand4 = cand_q[4];
  assign cand5 = cand_q[5];

  assign st0 = st_q[0];
  assign st1 = st_q[1];
  assign st2 = st_q[2];
  assign st3 = st_q[3];
  assign st4 = st_q[4];
  assign st5 = st_q[5];

endmodule

// File: tb/tb_hmlf6_state_update.sv
// -----------------------------------------------------------------------------
// tb_hmlf6_state_update
//
// Directed bench for hmlf6_state_update. The six-input min stage is modelled
// combinationally from the candidate outputs. Expected values are worked out
// by hand from the update rules, for both the clamping and the wrapping build.
// -----------------------------------------------------------------------------
module tb_hmlf6_state_update;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [5:0]        sel = '0;
  logic              sat_clr = 1'b0;
  logic              in_ready;
  logic signed [5:0] cand_w [6];
  logic signed [5:0] st_w   [6];
  logic signed [5:0] min_in;
  logic              out_valid;
  logic              sat_flag;
  logic              state_dbg;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  hmlf6_state_update dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .cand5      (cand_w[5]),
    .cand4      (cand_w[4]),
    .cand3      (cand_w[3]),
    .cand2      (cand_w[2]),
    .cand1      (cand_w[1]),
    .cand0      (cand_w[0]),
    .min_in     (min_in),
    .st5        (st_w[5]),
    .st4        (st_w[4]),
    .st3        (st_w[3]),
    .st2        (st_w[2]),
    .st1        (st_w[1]),
    .st0        (st_w[0]),
    .out_valid  (out_valid),
    .sat_flag   (sat_flag),
    .sat_clr    (sat_clr),
    .state_dbg_o(state_dbg)
  );

  // Min stage model
  always_comb begin
    min_in = cand_w[0];
    for (int i = 1; i < 6; i++) begin
      if (cand_w[i] < min_in) min_in = cand_w[i];
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    sel      = '0;
    sat_clr  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Offers a vector and returns just after the accepting edge (DUT in NORM).
  task automatic send(input logic [5:0] s);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    vec_count++;
    if (in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL send_wait: in_ready got %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    sel      = s;
    tick();
    in_valid = 1'b0;
  endtask

  // Full vector: returns just after the normalizing edge (out_valid high).
  task automatic run_vec(input logic [5:0] s);
    send(s);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    vec_count++;
    if (in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vec_count++;
    if (sat_flag !== 1'b0) begin
      err_count++;
      $display("FAIL reset_sat_flag: got %b expected 0", sat_flag);
    end
    for (int i = 0; i < 6; i++) begin
      vec_count++;
      if (cand_w[i] !== 6'sd0) begin
        err_count++;
        $display("FAIL reset_cand%0d: got %0d expected 0", i, cand_w[i]);
      end
      vec_count++;
      if (st_w[i] !== 6'sd0) begin
        err_count++;
        $display("FAIL reset_st%0d: got %0d expected 0", i, st_w[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_count++;
    if (in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_vector();
    logic signed [5:0] e;
    send(6'b000001);
    vec_count++;
    if (in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL single_busy: in_ready got %b expected 0", in_ready);
    end
    e = -6'sd5;
    vec_count++;
    if (cand_w[0] !== e) begin
      err_count++;
      $display("FAIL single_cand0: got %0d expected -5", cand_w[0]);
    end
    for (int i = 1; i < 6; i++) begin
      vec_count++;
      if (cand_w[i] !== 6'sd1) begin
        err_count++;
        $display("FAIL single_cand%0d: got %0d expected 1", i, cand_w[i]);
      end
    end
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL single_early_valid: got %b expected 0", out_valid);
    end
    tick();
    vec_count++;
    if (st_w[0] !== 6'sd0) begin
      err_count++;
      $display("FAIL single_st0: got %0d expected 0", st_w[0]);
    end
    for (int i = 1; i < 6; i++) begin
      vec_count++;
      if (st_w[i] !== 6'sd6) begin
        err_count++;
        $display("FAIL single_st%0d: got %0d expected 6", i, st_w[i]);
      end
    end
    vec_count++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL single_pulse: out_valid/in_ready got %b/%b expected 1/1",
               out_valid, in_ready);
    end
    tick();
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL single_pulse_end: got %b expected 0", out_valid);
    end
    // Idle: nothing may move.
    repeat (3) tick();
    vec_count++;
    if (st_w[1] !== 6'sd6 || cand_w[1] !== 6'sd1 || out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL idle_hold: st1/cand1/out_valid got %0d/%0d/%b expected 6/1/0",
               st_w[1], cand_w[1], out_valid);
    end
  endtask

  task automatic test_saturation();
    logic signed [5:0] exp_st [5];
    logic exp_flag;
    exp_st[0] = 6'sd12;
    exp_st[1] = 6'sd18;
    exp_st[2] = 6'sd24;
    exp_st[3] = 6'sd30;
`ifdef HMLF6_SAT_EN
    exp_st[4] = 6'sd31;
    exp_flag  = 1'b1;
`else
    exp_st[4] = -6'sd28;
    exp_flag  = 1'b0;
`endif
    for (int k = 0; k < 5; k++) begin
      run_vec(6'b000001);
      vec_count++;
      if (st_w[0] !== 6'sd0) begin
        err_count++;
        $display("FAIL sat_step%0d_st0: got %0d expected 0", k, st_w[0]);
      end
      for (int i = 1; i < 6; i++) begin
        vec_count++;
        if (st_w[i] !== exp_st[k]) begin
          err_count++;
          $display("FAIL sat_step%0d_st%0d: got %0d expected %0d",
                   k, i, st_w[i], exp_st[k]);
        end
      end
      if (k == 3) begin
        vec_count++;
        if (sat_flag !== 1'b0) begin
          err_count++;
          $display("FAIL sat_flag_early: got %b expected 0", sat_flag);
        end
      end
    end
    vec_count++;
    if (sat_flag !== exp_flag) begin
      err_count++;
      $display("FAIL sat_flag_set: got %b expected %b", sat_flag, exp_flag);
    end
    // Sticky across idle cycles, then cleared by sat_clr.
    repeat (2) tick();
    vec_count++;
    if (sat_flag !== exp_flag) begin
      err_count++;
      $display("FAIL sat_flag_sticky: got %b expected %b", sat_flag, exp_flag);
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    vec_count++;
    if (sat_flag !== 1'b0) begin
      err_count++;
      $display("FAIL sat_flag_clear: got %b expected 0", sat_flag);
    end
  endtask

  task automatic test_reset_mid_norm();
    send(6'b000001);
    rst_n = 1'b0;
    #1;
    vec_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_ctrl: in_ready/out_valid got %b/%b expected 1/0",
               in_ready, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      vec_count++;
      if (cand_w[i] !== 6'sd0 || st_w[i] !== 6'sd0) begin
        err_count++;
        $display("FAIL midreset_elem%0d: cand/st got %0d/%0d expected 0/0",
                 i, cand_w[i], st_w[i]);
      end
    end
    tick();
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_no_pulse: got %b expected 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_release_pulse: got %b expected 0", out_valid);
    end
    run_vec(6'b000001);
    vec_count++;
    if (st_w[0] !== 6'sd0 || st_w[3] !== 6'sd6 || out_valid !== 1'b1) begin
      err_count++;
      $display("FAIL midreset_next: st0/st3/out_valid got %0d/%0d/%b expected 0/6/1",
               st_w[0], st_w[3], out_valid);
    end
  endtask

  task automatic test_all_equal();
    logic [5:0] pats [2];
    pats[0] = 6'b111111;
    pats[1] = 6'b000000;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      send(pats[p]);
      for (int i = 0; i < 6; i++) begin
        vec_count++;
        if (cand_w[i] !== 6'sd0) begin
          err_count++;
          $display("FAIL equal_p%0d_cand%0d: got %0d expected 0", p, i, cand_w[i]);
        end
      end
      tick();
      for (int i = 0; i < 6; i++) begin
        vec_count++;
        if (st_w[i] !== 6'sd0) begin
          err_count++;
          $display("FAIL equal_p%0d_st%0d: got %0d expected 0", p, i, st_w[i]);
        end
      end
      vec_count++;
      if (out_valid !== 1'b1) begin
        err_count++;
        $display("FAIL equal_p%0d_pulse: got %b expected 1", p, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      // Odd cycles carry a pattern that would corrupt the states if taken.
      sel = (i % 2 == 0) ? 6'b000001 : 6'b111110;
      vec_count++;
      if (in_ready !== ((i % 2) == 0)) begin
        err_count++;
        $display("FAIL b2b_ready_c%0d: got %b expected %b", i, in_ready, (i % 2) == 0);
      end
      vec_count++;
      if (out_valid !== (i >= 2 && (i % 2) == 0)) begin
        err_count++;
        $display("FAIL b2b_valid_c%0d: got %b expected %b",
                 i, out_valid, (i >= 2 && (i % 2) == 0));
      end
      if (in_ready === 1'b1) accepted++;
      tick();
    end
    in_valid = 1'b0;
    vec_count++;
    if (accepted != 3) begin
      err_count++;
      $display("FAIL b2b_accepted: got %0d expected 3", accepted);
    end
    vec_count++;
    if (st_w[0] !== 6'sd0 || st_w[1] !== 6'sd18 || st_w[5] !== 6'sd18
        || out_valid !== 1'b1) begin
      err_count++;
      $display("FAIL b2b_result: st0/st1/st5/out_valid got %0d/%0d/%0d/%b expected 0/18/18/1",
               st_w[0], st_w[1], st_w[5], out_valid);
    end
  endtask

  task automatic test_sat_clr_collision();
    logic signed [5:0] e;
`ifdef HMLF6_SAT_EN
    e = 6'sd31;
`else
    e = -6'sd28;
`endif
    do_reset();
    repeat (5) run_vec(6'b000001);
    send(6'b000001);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    vec_count++;
    if (st_w[2] !== e) begin
      err_count++;
      $display("FAIL clr_clamp_st2: got %0d expected %0d", st_w[2], e);
    end
    vec_count++;
    if (sat_flag !== 1'b0) begin
      err_count++;
      $display("FAIL clr_priority: sat_flag got %b expected 0", sat_flag);
    end
    tick();
    vec_count++;
    if (sat_flag !== 1'b0) begin
      err_count++;
      $display("FAIL clr_priority_hold: sat_flag got %b expected 0", sat_flag);
    end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_saturation();
    test_reset_mid_norm();
    test_all_equal();
    test_back_to_back();
    test_sat_clr_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/hmlf6_state_update.md
HMLF6_STATE_UPDATE -- requirements
Module: hmlf6_state_update

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: a selection vector is present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a vector this cycle.
REQ-005 SHALL have port sel, input, 6 bits: unit-element usage vector (bit i = element i on).
REQ-006 SHALL have ports cand5..cand0, output, signed 6 bits each: registered candidate states, driven to the 6-input min stage inputs a5..a0.
REQ-007 SHALL have port min_in, input, signed 6 bits: minimum of cand5..cand0, returned combinationally by the min stage.
REQ-008 SHALL have ports st5..st0, output, signed 6 bits each: normalized shaping states.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse when st5..st0 were updated.
REQ-010 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.
REQ-011 SHALL have port sat_clr, input, 1 bit: synchronous clear of sat_flag.

Function
REQ-012 SHALL implement a 2-state FSM: ACC (in_ready=1) and NORM (in_ready=0).
REQ-013 SHALL, in ACC with in_valid=1, load cand_i <= st_i + popcount(sel) - 6*sel_i and move to NORM.
- Intermediate arithmetic is at least 8-bit signed.
REQ-014 SHALL, in ACC with in_valid=0, hold all registers and stay in ACC.
REQ-015 SHALL, in NORM, load st_i <= cand_i - min_in, pulse out_valid on the next cycle, and return to ACC.
REQ-016 SHALL ignore in_valid and sel while in NORM; vectors are not queued.
- Throughput: one vector per 2 cycles.
- Latency: vector accepted at edge N -> st updated at edge N+1 -> out_valid high during cycle N+1..N+2.
REQ-017 SHALL sample min_in only in NORM.
- min_in is produced combinationally from the registered cand outputs.
REQ-018 SHALL leave st unchanged when sel=6'b000000 or sel=6'b111111 and all states are equal.
REQ-019 SHALL give sat_clr priority under a simultaneous set-and-clear: the flag clears and the saturation event is lost.

Reset
REQ-020 SHALL, while rst_n=0, force the following regardless of clk:
- FSM=ACC
- cand*=0, st*=0
- out_valid=0, sat_flag=0
- in_ready=1 after release
REQ-021 SHALL abort a NORM cycle in progress when reset is asserted mid-operation, with no out_valid pulse.

Configuration
REQ-022 SHALL honour macro HMLF6_SAT_EN:
- Defined: cand and st results outside -32..31 are clamped to -32 or 31, and sat_flag sets on any clamp.
- Undefined: results wrap two's-complement to 6 bits, and sat_flag is tied to 0.

Verification
REQ-023 Reset, then sel=6'b000001 accepted -> cand0=-5, cand1..5=1; min_in=-5 -> st0=0, st1..5=6; out_valid 1 cycle.
REQ-024 Repeat sel=6'b000001 five more times:
- With HMLF6_SAT_EN: st1..5 = 12, 18, 24, 30, then clamp at 31; sat_flag=1.
- Without HMLF6_SAT_EN: 6th result = -28; sat_flag=0.
REQ-025 in_valid held high for 6 cycles -> in_ready = 1,0,1,0,1,0 and exactly 3 vectors accepted.
REQ-026 sel=6'b111111 and sel=6'b000000 from all-zero states -> st stays 0, out_valid still pulses.
REQ-027 rst_n dropped during NORM -> all outputs 0 immediately, no out_valid, next vector processed normally.
REQ-028 sat_clr=1 in the same cycle as a clamp -> sat_flag=0 afterwards.
